// File: rtl/rst_seq_gen.sv
// ---------------------------------------------------------------------------
// rst_seq_gen
//
// Soft-reset sequencer for the TRNG/CC reset domain. Merges NUM_SRC
// asynchronous soft-reset requests with the system reset and produces a
// glitch-free, retriggerable, active-low reset of guaranteed minimum width.
// Keeps sticky per-source cause flags and offers a scan-mode bypass.
//
// Ports:
//   clk         in   block clock, rising edge
//   sys_rst_n   in   system reset, asynchronous assert, active-low
//   sw_rst_req  in   [NUM_SRC] soft-reset requests, active-high, async to clk
//   cause_clr   in   one-cycle synchronous pulse, clears rst_cause
//   scan_mode   in   1 = DFT bypass, rst_n follows sys_rst_n
//   rst_n       out  generated reset, active-low
//   rst_busy    out  1 while a soft reset is being held
//   rst_cause   out  [NUM_SRC] sticky flag per source that triggered a reset
//
// Optional feature macro: RST_SEQ_POR_STRETCH_EN
//   When defined, the sequencer comes out of system reset already holding a
//   soft reset, so rst_n stays low HOLD_CYCLES cycles past sys_rst_n release.
// ---------------------------------------------------------------------------
module rst_seq_gen #(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [NUM_SRC-1:0] sw_rst_req,
  input  logic               cause_clr,
  input  logic               scan_mode,
  output logic               rst_n,
  output logic               rst_busy,
  output logic [NUM_SRC-1:0] rst_cause
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // Reset values of the sequencer core; the stretch option starts in HOLD.
`ifdef RST_SEQ_POR_STRETCH_EN
  localparam state_t           RST_STATE = HOLD;
  localparam logic [CNT_W-1:0] RST_CNT   = HOLD_LOAD;
  localparam logic             RST_NQ    = 1'b0;
  localparam logic             RST_BUSY  = 1'b1;
`else
  localparam state_t           RST_STATE = IDLE;
  localparam logic [CNT_W-1:0] RST_CNT   = '0;
  localparam logic             RST_NQ    = 1'b1;
  localparam logic             RST_BUSY  = 1'b0;
`endif

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] req_s_d;
  logic [NUM_SRC-1:0] req_rise;
  logic [NUM_SRC-1:0] rise_q;
  logic [NUM_SRC-1:0] lvl_q;
  logic               any_rise;
  logic               any_lvl;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rst_n_q;

  // Multi-flop synchroniser per request bit.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sw_rst_req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_s_d;

  // Edge history plus a registered copy of rise and level. The FSM acts on
  // the registered copies, which places the rst_n fall SYNC_STAGES+1 edges
  // after the request is first sampled, and keeps the level-extension view
  // aligned with the rise view.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_s_d <= '0;
      rise_q  <= '0;
      lvl_q   <= '0;
    end else begin
      req_s_d <= req_s;
      rise_q  <= req_rise;
      lvl_q   <= req_s;
    end
  end

  assign any_rise = |rise_q;
  assign any_lvl  = |lvl_q;

  // Hold sequencer: a rise enters or re-arms HOLD with a full count, the
  // counter runs down, and HOLD is left only once the count is spent and no
  // request level remains.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= RST_STATE;
      cnt      <= RST_CNT;
      rst_n_q  <= RST_NQ;
      rst_busy <= RST_BUSY;
    end else begin
      case (state)
        IDLE: begin
          if (any_rise) begin
            state    <= HOLD;
            cnt      <= HOLD_LOAD;
            rst_n_q  <= 1'b0;
            rst_busy <= 1'b1;
          end
        end
        HOLD: begin
          if (any_rise) begin
            cnt <= HOLD_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!any_lvl) begin
            state    <= IDLE;
            rst_n_q  <= 1'b1;
            rst_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          rst_n_q  <= 1'b1;
          rst_busy <= 1'b0;
        end
      endcase
    end
  end

  // Sticky cause flags. A clear wipes every bit except those being set in
  // the same cycle, so a fresh trigger is never lost to a concurrent clear.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_cause <= '0;
    end else if (cause_clr) begin
      rst_cause <= rise_q;
    end else begin
      rst_cause <= rst_cause | rise_q;
    end
  end

  // System reset reaches rst_n combinationally in both directions; scan
  // mode hides the soft reset so DFT sees only the system reset.
  assign rst_n = scan_mode ? sys_rst_n : (sys_rst_n & rst_n_q);

endmodule

// File: tb/tb_rst_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_gen
//
// Self-checking bench for rst_seq_gen (NUM_SRC=2, SYNC_STAGES=2,
// HOLD_CYCLES=4). A behavioural model keeps the list of request samples
// taken at each clock edge since the last system reset and derives the
// expected outputs from the timing rules: a rise is seen three edges after
// it is sampled, the reset is held for HOLD_CYCLES edges after the last
// rise, and is extended while a delayed request level stays high.
// ---------------------------------------------------------------------------
module tb_rst_seq_gen;

  localparam int NUM_SRC     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int CNT_W       = 4;
  localparam int LAT         = SYNC_STAGES + 1;

  logic               clk;
  logic               sys_rst_n;
  logic [NUM_SRC-1:0] sw_rst_req;
  logic               cause_clr;
  logic               scan_mode;
  logic               rst_n;
  logic               rst_busy;
  logic [NUM_SRC-1:0] rst_cause;

  int checkCount = 0;
  int errorCount = 0;

  // Model state
  logic [NUM_SRC-1:0] hist[$];
  int                 lastRise;
  logic               busyM;
  logic [NUM_SRC-1:0] causeM;

  rst_seq_gen #(
    .NUM_SRC    (NUM_SRC),
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .sw_rst_req(sw_rst_req),
    .cause_clr (cause_clr),
    .scan_mode (scan_mode),
    .rst_n     (rst_n),
    .rst_busy  (rst_busy),
    .rst_cause (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model after a system reset release: empty sample history.
  task automatic modelReset();
    hist.delete();
    causeM = '0;
`ifdef RST_SEQ_POR_STRETCH_EN
    lastRise = -1;
    busyM    = 1'b1;
`else
    lastRise = -1000;
    busyM    = 1'b0;
`endif
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic modelEdge();
    int k;
    logic [NUM_SRC-1:0] lvl;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    hist.push_back(sw_rst_req);
    k    = hist.size() - 1;
    lvl  = (k >= LAT)     ? hist[k-LAT]   : '0;
    prev = (k >= LAT + 1) ? hist[k-LAT-1] : '0;
    rise = lvl & ~prev;
    causeM = cause_clr ? rise : (causeM | rise);
    if (rise != '0) lastRise = k;
    busyM = ((k - lastRise) < HOLD_CYCLES) || (busyM && (lvl != '0));
  endtask

  task automatic checkAll(input string tag);
    logic expRstN;
    expRstN = scan_mode ? sys_rst_n : (sys_rst_n & ~busyM);
    checkOutput({tag, ".rst_n"}, 32'(rst_n), 32'(expRstN));
    checkOutput({tag, ".busy"}, 32'(rst_busy), 32'(busyM));
    checkOutput({tag, ".cause"}, 32'(rst_cause), 32'(causeM));
  endtask

  // Drive one input pattern for n cycles; inputs change on the falling edge
  // and outputs are checked on the falling edge before the next change.
  task automatic applyStimulus(input logic [NUM_SRC-1:0] req, input logic clr,
                               input logic scan, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sw_rst_req = req;
      cause_clr  = clr;
      scan_mode  = scan;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll(tag);
    end
    cause_clr = 1'b0;
  endtask

  // Assert system reset asynchronously, check the immediate effect, release.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput({tag, ".rst_n_async"}, 32'(rst_n), 32'd0);
    checkOutput({tag, ".busy_rst"}, 32'(rst_busy), 32'(RstBusyVal()));
    checkOutput({tag, ".cause_rst"}, 32'(rst_cause), 32'd0);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    modelReset();
    #1;
    checkAll({tag, "_rel"});
  endtask

  function automatic logic RstBusyVal();
`ifdef RST_SEQ_POR_STRETCH_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [NUM_SRC-1:0] rreq;
    logic               rscan;
    sys_rst_n  = 1'b0;
    sw_rst_req = '0;
    cause_clr  = 1'b0;
    scan_mode  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("por.rst_n", 32'(rst_n), 32'd0);
    checkOutput("por.cause", 32'(rst_cause), 32'd0);

    // Case 1: release with no requests
    sys_rst_n = 1'b1;
    #1;
    checkAll("rel");
    applyStimulus(2'b00, 1'b0, 1'b0, 8, "idle");

    // Case 2: single-cycle pulse on req[0]
    applyStimulus(2'b01, 1'b0, 1'b0, 1, "pulse0");
    applyStimulus(2'b00, 1'b0, 1'b0, 10, "pulse0_tail");
    applyStimulus(2'b00, 1'b1, 1'b0, 1, "clr");

    // Case 3: req[1] held 12 cycles, level extension
    applyStimulus(2'b10, 1'b0, 1'b0, 12, "hold1");
    applyStimulus(2'b00, 1'b0, 1'b0, 8, "hold1_tail");
    applyStimulus(2'b00, 1'b1, 1'b0, 1, "clr");

    // Case 4: retrigger two cycles into HOLD, then clear racing a new rise
    applyStimulus(2'b01, 1'b0, 1'b0, 1, "retrig_a");
    applyStimulus(2'b00, 1'b0, 1'b0, 1, "retrig_gap");
    applyStimulus(2'b10, 1'b0, 1'b0, 1, "retrig_b");
    applyStimulus(2'b00, 1'b0, 1'b0, 12, "retrig_tail");
    applyStimulus(2'b01, 1'b0, 1'b0, 1, "race_req");
    applyStimulus(2'b00, 1'b0, 1'b0, 2, "race_wait");
    applyStimulus(2'b00, 1'b1, 1'b0, 1, "race_clr");
    applyStimulus(2'b00, 1'b0, 1'b0, 8, "race_tail");
    applyStimulus(2'b00, 1'b1, 1'b0, 1, "clr");

    // Case 5: scan bypass
    applyStimulus(2'b01, 1'b0, 1'b1, 1, "scan");
    applyStimulus(2'b00, 1'b0, 1'b1, 10, "scan_tail");
    applyStimulus(2'b00, 1'b1, 1'b0, 1, "clr");

    // Case 6: system reset mid-HOLD
    applyStimulus(2'b01, 1'b0, 1'b0, 1, "abort");
    applyStimulus(2'b00, 1'b0, 1'b0, 5, "abort_hold");
    doReset("abort");
    applyStimulus(2'b00, 1'b0, 1'b0, 10, "abort_after");

    // Randomised traffic with occasional system resets
    rreq  = '0;
    rscan = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NUM_SRC; b++) begin
        if ($urandom_range(0, 9) == 0) rreq[b] = ~rreq[b];
      end
      if ($urandom_range(0, 99) == 0) rscan = ~rscan;
      applyStimulus(rreq, ($urandom_range(0, 7) == 0), rscan, 1, "rand");
      if ($urandom_range(0, 249) == 0) doReset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Parametrised soft-reset sequencer for the TRNG/CC reset domain. It merges NUM_SRC asynchronous soft-reset requests with the system reset. Each request is synchronised and edge-detected, then produces a glitch-free, retriggerable active-low reset pulse of guaranteed minimum width. It also keeps sticky per-source cause flags and provides a scan-mode bypass. It sits at the top of each engine's reset tree, between the system reset input and the engine's local rst_n.

Parameters:
NUM_SRC, 2, number of soft-reset request inputs (>=1)
SYNC_STAGES, 2, synchroniser depth per request (>=2)
HOLD_CYCLES, 4, minimum rst_n low time in clk cycles (>=1)
CNT_W, 4, hold counter width; must satisfy 2**CNT_W > HOLD_CYCLES-1

Ports:
clk  input  1  block clock, rising edge
sys_rst_n  input  1  system reset, asynchronous assert, active-low
sw_rst_req  input  NUM_SRC  soft-reset requests, active-high, asynchronous to clk
cause_clr  input  1  synchronous one-cycle pulse; clears rst_cause
scan_mode  input  1  1 = DFT bypass
rst_n  output  1  generated reset, active-low
rst_busy  output  1  1 while the sequencer holds a soft reset
rst_cause  output  NUM_SRC  sticky bit per source that triggered a soft reset

Behaviour:
- Reset domain: one clock, clk. All flops reset asynchronously when sys_rst_n=0 (active-low). Reset values: sync chains 0, edge-history 0, state IDLE, counter 0, rst_n_q 1, rst_busy 0, rst_cause 0.
- Output function: rst_n = scan_mode ? sys_rst_n : (sys_rst_n & rst_n_q).
  - Assertion of sys_rst_n drives rst_n low combinationally.
  - Release of sys_rst_n takes rst_n high immediately, unless the optional feature is compiled in.
- Synchronisation: each sw_rst_req[i] passes through a SYNC_STAGES flop chain giving req_s[i]. req_rise[i] = req_s[i] & ~req_s_d[i], where req_s_d is a one-flop history.
- FSM, two states:
  - IDLE: rst_n_q=1, rst_busy=0. If any req_rise is set: go to HOLD, load cnt=HOLD_CYCLES-1, clear rst_n_q to 0, set rst_busy to 1, all on the same edge.
  - HOLD, retrigger: any req_rise reloads cnt=HOLD_CYCLES-1.
  - HOLD, count: otherwise, if cnt!=0, decrement cnt.
  - HOLD, exit: if cnt==0, no req_rise, and all req_s are 0: go to IDLE, set rst_n_q to 1, clear rst_busy to 0.
  - HOLD, extend: if cnt==0 and any req_s is still 1, stay in HOLD (level extension).
- Latency: rst_n falls SYNC_STAGES+1 rising edges after the edge that first samples sw_rst_req high. A single-cycle request pulse synchronous to clk must be captured.
- Width: rst_n stays low for exactly HOLD_CYCLES cycles after the last rise, or longer if a request level is still held.
- rst_cause:
  - rst_cause[i] is set on req_rise[i] and cleared by cause_clr.
  - If set and clear occur in the same cycle, set wins for that bit; other bits clear.
  - Cleared only by sys_rst_n or cause_clr; never cleared by the soft reset this block generates.
- Scan: with scan_mode=1 the FSM, rst_busy and rst_cause operate normally; only rst_n is bypassed.
- sys_rst_n asserted mid-HOLD aborts the sequence. All state returns to reset values and the request is lost.

Optional Feature:
Macro RST_SEQ_POR_STRETCH_EN.
- Defined: reset values become state=HOLD, cnt=HOLD_CYCLES-1, rst_n_q=0, rst_busy=1. On sys_rst_n release, rst_n stays low for HOLD_CYCLES more cycles (plus extension if a request is held). rst_cause stays 0.
- Undefined: reset values as listed under Behaviour; rst_n rises with sys_rst_n.

Test Plan:
(All cases use NUM_SRC=2, SYNC_STAGES=2, HOLD_CYCLES=4.)
1. Release sys_rst_n with no requests -> rst_n=1 at once, rst_busy=0, rst_cause=2'b00. With macro defined: rst_n=0 and rst_busy=1 for 4 cycles, then rst_n=1.
2. One-cycle pulse on sw_rst_req[0] sampled at edge E0 -> rst_n falls at E3 and rises at E7; rst_busy high E3..E7; rst_cause=2'b01.
3. sw_rst_req[1] held high 12 cycles -> rst_n low from E3 until the edge after req_s[1] returns to 0 (E15), longer than 4 cycles; rst_cause=2'b10.
4. Rise on req[0] at E0, then rise on req[1] two cycles into HOLD -> counter reloads, rst_n low 6 cycles total, rst_cause=2'b11. A later cause_clr in the same cycle as a new req[0] rise -> rst_cause=2'b01.
5. scan_mode=1 with a req[0] pulse -> rst_n stays 1 (follows sys_rst_n), rst_busy still pulses 4 cycles, rst_cause=2'b01.
6. sys_rst_n driven low mid-HOLD -> rst_n=0 combinationally, rst_cause=2'b00. On release, rst_n=1 and rst_busy=0 with macro undefined; no residual soft reset.
